slot_alloc: RTL and testbench

Occupancy tracker and slot allocator for the sparse accelerator's N-entry buffers. It owns the occupancy bit vector that the zero-counter search consumes. On allocate it finds the lowest-index free slot, marks it busy and returns its index. On free it clears a slot's bit. Producers call it to claim entries; consumers call it to release them.

---
 rtl/slot_alloc_if.sv | 28 ++
 rtl/slot_alloc.sv | 84 ++++++++
 tb/tb_slot_alloc.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/slot_alloc_if.sv
// Request/response bundle for the slot allocator: alloc/free requests in,
// grant/fail/error pulses and occupancy status out.
interface slot_alloc_if #(
    parameter int unsigned N      = 8,
    parameter int unsigned ADDR_W = 3
);
    logic              alloc_req;
    logic              free_req;
    logic [ADDR_W-1:0] free_addr;
    logic              alloc_valid;
    logic              alloc_fail;
    logic [ADDR_W-1:0] alloc_addr;
    logic [N-1:0]      occ;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              err_free;

    modport master (
        output alloc_req, free_req, free_addr,
        input  alloc_valid, alloc_fail, alloc_addr, occ, count, full, empty, err_free
    );

    modport slave (
        input  alloc_req, free_req, free_addr,
        output alloc_valid, alloc_fail, alloc_addr, occ, count, full, empty, err_free
    );
endinterface

// File: rtl/slot_alloc.sv
// Occupancy tracker and lowest-free-slot allocator for an N-entry buffer.
// One alloc and one free may be resolved per cycle; all results are registered.
module slot_alloc #(
    parameter int unsigned N      = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    slot_alloc_if.slave  bus
);

    localparam int unsigned Slots = 2 ** ADDR_W;

    logic [N-1:0]      occ_q, occ_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] alloc_addr_q, alloc_addr_d;
    logic              alloc_valid_q, alloc_valid_d;
    logic              alloc_fail_q, alloc_fail_d;
    logic              err_free_q, err_free_d;

    logic              hit;
    logic [ADDR_W-1:0] idx;
    logic              grant;
    logic              free_legal;
    logic [Slots-1:0]  occ_ext;
    logic [N-1:0]      set_mask;
    logic [N-1:0]      clr_mask;

    // Lowest-index free slot among the N real slots of the registered vector.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!occ_q[i] && !hit) begin
                hit = 1'b1;
                idx = ADDR_W'(i);
            end
        end
    end

    // Zero-extended view so out-of-range free addresses read as "not busy".
    assign occ_ext    = Slots'(occ_q);
    assign grant      = bus.alloc_req && hit;
    assign free_legal = bus.free_req && (32'(bus.free_addr) < N) && occ_ext[bus.free_addr];

    always_comb begin
        set_mask      = grant      ? (N'(1) << idx)           : '0;
        clr_mask      = free_legal ? (N'(1) << bus.free_addr) : '0;
        occ_d         = (occ_q | set_mask) & ~clr_mask;
        count_d       = count_q + (ADDR_W + 1)'(grant) - (ADDR_W + 1)'(free_legal);
        alloc_addr_d  = grant ? idx : alloc_addr_q;
        alloc_valid_d = grant;
        alloc_fail_d  = bus.alloc_req && !hit;
        err_free_d    = bus.free_req && !free_legal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q         <= '0;
            count_q       <= '0;
            alloc_addr_q  <= '0;
            alloc_valid_q <= 1'b0;
            alloc_fail_q  <= 1'b0;
            err_free_q    <= 1'b0;
        end else begin
            occ_q         <= occ_d;
            count_q       <= count_d;
            alloc_addr_q  <= alloc_addr_d;
            alloc_valid_q <= alloc_valid_d;
            alloc_fail_q  <= alloc_fail_d;
            err_free_q    <= err_free_d;
        end
    end

    assign bus.occ         = occ_q;
    assign bus.count       = count_q;
    assign bus.alloc_addr  = alloc_addr_q;
    assign bus.alloc_valid = alloc_valid_q;
    assign bus.alloc_fail  = alloc_fail_q;
    assign bus.err_free    = err_free_q;
    assign bus.full        = (count_q == (ADDR_W + 1)'(N));
    assign bus.empty       = (count_q == '0);

endmodule

// File: tb/tb_slot_alloc.sv
// Bench for slot_alloc: an N=8 and an N=6 instance share stimulus and are
// compared every cycle against an array-based model of the allocation rules.
module tb_slot_alloc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    slot_alloc_if #(.N(8), .ADDR_W(3)) bus0 ();
    slot_alloc_if #(.N(6), .ADDR_W(3)) bus1 ();

    slot_alloc #(.N(8), .ADDR_W(3)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    slot_alloc #(.N(6), .ADDR_W(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int errors = 0;
    int checks = 0;

    int       m_n[2] = '{8, 6};
    bit [7:0] m_occ[2];
    int       m_addr[2];
    bit       e_valid[2], e_fail[2], e_err[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit a, input bit f, input int fa);
        bus0.alloc_req = a;  bus0.free_req = f;  bus0.free_addr = 3'(fa);
        bus1.alloc_req = a;  bus1.free_req = f;  bus1.free_addr = 3'(fa);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_occ[k] = '0; m_addr[k] = 0;
            e_valid[k] = 0; e_fail[k] = 0; e_err[k] = 0;
        end
    endtask

    // Allocation rules: grant lowest free slot of the pre-cycle state, free only busy slots < n.
    task automatic model_step(input bit a, input bit f, input int fa);
        for (int k = 0; k < 2; k++) begin
            int  found = -1;
            bit  legal;
            for (int i = 0; i < m_n[k]; i++)
                if (!m_occ[k][i] && found < 0) found = i;
            legal      = f && (fa < m_n[k]) && m_occ[k][fa];
            e_valid[k] = a && (found >= 0);
            e_fail[k]  = a && (found < 0);
            e_err[k]   = f && !legal;
            if (legal) m_occ[k][fa] = 1'b0;
            if (e_valid[k]) begin
                m_occ[k][found] = 1'b1;
                m_addr[k] = found;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [7:0] o_occ[2];
        logic [3:0] o_cnt[2];
        logic       o_val[2], o_fail[2], o_err[2], o_full[2], o_empty[2];
        logic [2:0] o_addr[2];
        o_occ[0] = bus0.occ;          o_occ[1] = {2'b00, bus1.occ};
        o_cnt[0] = bus0.count;        o_cnt[1] = bus1.count;
        o_val[0] = bus0.alloc_valid;  o_val[1] = bus1.alloc_valid;
        o_fail[0] = bus0.alloc_fail;  o_fail[1] = bus1.alloc_fail;
        o_err[0] = bus0.err_free;     o_err[1] = bus1.err_free;
        o_full[0] = bus0.full;        o_full[1] = bus1.full;
        o_empty[0] = bus0.empty;      o_empty[1] = bus1.empty;
        o_addr[0] = bus0.alloc_addr;  o_addr[1] = bus1.alloc_addr;
        for (int k = 0; k < 2; k++) begin
            int c = $countones(m_occ[k]);
            string p = $sformatf("%s/n%0d", tag, m_n[k]);
            chk({p, ".occ"}, 32'(o_occ[k]), 32'(m_occ[k]));
            chk({p, ".count"}, 32'(o_cnt[k]), 32'(c));
            chk({p, ".alloc_valid"}, 32'(o_val[k]), 32'(e_valid[k]));
            chk({p, ".alloc_fail"}, 32'(o_fail[k]), 32'(e_fail[k]));
            chk({p, ".err_free"}, 32'(o_err[k]), 32'(e_err[k]));
            chk({p, ".alloc_addr"}, 32'(o_addr[k]), 32'(m_addr[k]));
            chk({p, ".full"}, 32'(o_full[k]), 32'(c == m_n[k]));
            chk({p, ".empty"}, 32'(o_empty[k]), 32'(c == 0));
        end
    endtask

    task automatic cyc(input string tag, input bit a, input bit f, input int fa);
        drive(a, f, fa);
        @(posedge clk);
        model_step(a, f, fa);
        #1;
        drive(0, 0, 0);
        compare_all(tag);
    endtask

    initial begin
        drive(0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Fill: N=8 grants 0..7, N=6 fails after slot 5.
        for (int i = 0; i < 8; i++) begin
            cyc("fill", 1, 0, 0);
            chk("fill.addr_seq", 32'(bus0.alloc_addr), 32'(i));
        end
        chk("full.occ_ff", 32'(bus0.occ), 32'hFF);
        chk("full.flag", 32'(bus0.full), 32'd1);
        cyc("alloc_on_full", 1, 0, 0);
        chk("alloc_on_full.fail", 32'(bus0.alloc_fail), 32'd1);

        cyc("free5", 0, 1, 5);
        cyc("free2", 0, 1, 2);
        cyc("realloc_a", 1, 0, 0);
        chk("realloc_a.addr", 32'(bus0.alloc_addr), 32'd2);
        cyc("realloc_b", 1, 0, 0);
        chk("realloc_b.addr", 32'(bus0.alloc_addr), 32'd5);
        chk("realloc_b.count", 32'(bus0.count), 32'd8);

        // Full plus simultaneous free: alloc still fails, freed slot granted next cycle.
        cyc("full_af", 1, 1, 3);
        chk("full_af.occ", 32'(bus0.occ), 32'hF7);
        chk("full_af.fail", 32'(bus0.alloc_fail), 32'd1);
        cyc("after_af", 1, 0, 0);
        chk("after_af.addr", 32'(bus0.alloc_addr), 32'd3);

        foreach (m_n[j]) begin end
        cyc("to0b", 0, 1, 2);
        cyc("to0b", 0, 1, 4);
        cyc("to0b", 0, 1, 5);
        cyc("to0b", 0, 1, 6);
        cyc("to0b", 0, 1, 7);
        chk("to0b.occ", 32'(bus0.occ), 32'h0B);
        cyc("mixed_af", 1, 1, 1);
        chk("mixed_af.addr", 32'(bus0.alloc_addr), 32'd2);
        chk("mixed_af.occ", 32'(bus0.occ), 32'h0D);
        chk("mixed_af.count", 32'(bus0.count), 32'd3);

        cyc("to01", 0, 1, 2);
        cyc("to01", 0, 1, 3);
        cyc("bad_free6", 0, 1, 6);
        chk("bad_free6.err", 32'(bus0.err_free), 32'd1);
        cyc("bad_free7", 0, 1, 7);
        chk("bad_free7.err_n6", 32'(bus1.err_free), 32'd1);

        // Build 8'h3C then reset asynchronously between edges with a request pending.
        for (int i = 0; i < 5; i++) cyc("to3c", 1, 0, 0);
        cyc("to3c", 0, 1, 0);
        cyc("to3c", 0, 1, 1);
        chk("to3c.occ", 32'(bus0.occ), 32'h3C);
        @(negedge clk);
        drive(1, 1, 2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all("async_rst");
        @(posedge clk);
        #1;
        compare_all("in_rst");
        @(negedge clk);
        drive(0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compare_all("post_rst");
        cyc("post_rst_alloc", 1, 0, 0);
        chk("post_rst_alloc.addr", 32'(bus0.alloc_addr), 32'd0);
        chk("post_rst_alloc.valid", 32'(bus0.alloc_valid), 32'd1);

        for (int i = 0; i < 400; i++) begin
            bit a = ($urandom % 100) < 55;
            bit f = ($urandom % 100) < 45;
            int fa = int'($urandom % 8);
            cyc("rand", a, f, fa);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
